// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the RV32IM pipeline.
//   - default datapath / register-index / ALUOP widths
//   - base opcode values used by decode-side logic
//   - ALUOP encodings produced by CONTROL_UNIT
//   - operand-usage helpers used by the load-use hazard check
package rv32_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int REG_AW_DEFAULT  = 5;
    localparam int ALUOP_W_DEFAULT = 5;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [4:0] ALU_ADD    = 5'd1;
    localparam logic [4:0] ALU_SUB    = 5'd2;
    localparam logic [4:0] ALU_SLL    = 5'd3;
    localparam logic [4:0] ALU_SLT    = 5'd4;
    localparam logic [4:0] ALU_SLTU   = 5'd5;
    localparam logic [4:0] ALU_XOR    = 5'd6;
    localparam logic [4:0] ALU_SRL    = 5'd7;
    localparam logic [4:0] ALU_SRA    = 5'd8;
    localparam logic [4:0] ALU_OR     = 5'd9;
    localparam logic [4:0] ALU_AND    = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    // True when the instruction reads rs1. Unknown opcodes read nothing,
    // so a garbage word in ID can never create a stall.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OP_RTYPE, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH: r = 1'b1;
            default:                                                r = 1'b0;
        endcase
        return r;
    endfunction

    // True when the instruction reads rs2.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OP_RTYPE, OP_STORE, OP_BRANCH: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard check between the
// instruction currently in EX and the one in ID.
// Ports:
//   i_ex_valid, i_ex_memread, i_ex_rd : EX-stage instruction state
//   i_id_valid, i_opcode, i_rs1, i_rs2 : ID-stage instruction fields
//   o_stall                            : ID consumer needs the EX load result
module load_use_detect
    import rv32_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_id_valid,
    input  logic [6:0]        i_opcode,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_stall
);

    logic w_load_in_ex;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // Hazard evaluation. Every term is gated by a registered valid bit, so
    // bubbles (all-zero EX state) can never request a stall; rd=x0 never stalls.
    always_comb begin
        w_load_in_ex = i_ex_valid & i_ex_memread & (i_ex_rd != {REG_AW{1'b0}});
        w_rs1_hit    = uses_rs1(i_opcode) & (i_rs1 == i_ex_rd);
        w_rs2_hit    = uses_rs2(i_opcode) & (i_rs2 == i_ex_rd);
        if (w_load_in_ex && i_id_valid) begin
            o_stall = w_rs1_hit | w_rs2_hit;
        end else begin
            o_stall = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX pipeline register of the RV32IM 5-stage core.
// Captures decoded controls, operands, immediate, PC and instruction fields
// and presents them to EX one cycle later. Contains the load-use detector.
// Edge priority: RESET low > HOLD > FLUSH > load-use bubble > capture.
// Ports:
//   CLK, RESET (sync, active low)
//   INSTRUCTION, ID_VALID, ID_PC, ID_DATA1/2, ID_IMM : ID-side datapath
//   ALUOP, MUX1..4_SELECT, WRITEENABLE, MEMREAD, MEMWRITE, BRANCH, JUMP
//   HOLD (freeze), FLUSH (kill ID instruction)
//   EX_* : registered copies for EX; LOAD_USE_STALL : combinational stall
module id_ex_pipeline_reg
    import rv32_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int REG_AW  = REG_AW_DEFAULT,
    parameter int ALUOP_W = ALUOP_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        INSTRUCTION,
    input  logic               ID_VALID,
    input  logic [XLEN-1:0]    ID_PC,
    input  logic [XLEN-1:0]    ID_DATA1,
    input  logic [XLEN-1:0]    ID_DATA2,
    input  logic [XLEN-1:0]    ID_IMM,
    input  logic [ALUOP_W-1:0] ALUOP,
    input  logic               MUX1_SELECT,
    input  logic               MUX2_SELECT,
    input  logic               MUX3_SELECT,
    input  logic               MUX4_SELECT,
    input  logic               WRITEENABLE,
    input  logic               MEMREAD,
    input  logic               MEMWRITE,
    input  logic               BRANCH,
    input  logic               JUMP,
    input  logic               HOLD,
    input  logic               FLUSH,
    output logic               EX_VALID,
    output logic [XLEN-1:0]    EX_PC,
    output logic [XLEN-1:0]    EX_DATA1,
    output logic [XLEN-1:0]    EX_DATA2,
    output logic [XLEN-1:0]    EX_IMM,
    output logic [ALUOP_W-1:0] EX_ALUOP,
    output logic               EX_MUX1,
    output logic               EX_MUX2,
    output logic               EX_MUX3,
    output logic               EX_MUX4,
    output logic               EX_WRITEENABLE,
    output logic               EX_MEMREAD,
    output logic               EX_MEMWRITE,
    output logic               EX_BRANCH,
    output logic               EX_JUMP,
    output logic [REG_AW-1:0]  EX_RD,
    output logic [REG_AW-1:0]  EX_RS1,
    output logic [REG_AW-1:0]  EX_RS2,
    output logic [2:0]         EX_FUNCT3,
    output logic               LOAD_USE_STALL
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    data1;
        logic [XLEN-1:0]    data2;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] aluop;
        logic               mux1;
        logic               mux2;
        logic               mux3;
        logic               mux4;
        logic               we;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic               jump;
        logic [REG_AW-1:0]  rd;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [2:0]         funct3;
    } ex_t;

    ex_t  r_ex;
    ex_t  w_next;
    logic w_stall;
    logic w_bubble;
    logic w_unused_funct7;

    // funct7 is consumed by CONTROL_UNIT, not by this stage.
    assign w_unused_funct7 = &{1'b0, INSTRUCTION[31:25]};

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .i_ex_valid   (r_ex.valid),
        .i_ex_memread (r_ex.memread),
        .i_ex_rd      (r_ex.rd),
        .i_id_valid   (ID_VALID),
        .i_opcode     (INSTRUCTION[6:0]),
        .i_rs1        (INSTRUCTION[19:15]),
        .i_rs2        (INSTRUCTION[24:20]),
        .o_stall      (w_stall)
    );

    // Next EX contents: a bubble is the all-zero word, which also scrubs any
    // don't-care control values that CONTROL_UNIT drives for non-instructions.
    always_comb begin
        w_next   = '0;
        w_bubble = FLUSH | w_stall | ~ID_VALID;
        if (w_bubble) begin
            w_next = '0;
        end else begin
            w_next.valid    = 1'b1;
            w_next.pc       = ID_PC;
            w_next.data1    = ID_DATA1;
            w_next.data2    = ID_DATA2;
            w_next.imm      = ID_IMM;
            w_next.aluop    = ALUOP;
            w_next.mux1     = MUX1_SELECT;
            w_next.mux2     = MUX2_SELECT;
            w_next.mux3     = MUX3_SELECT;
            w_next.mux4     = MUX4_SELECT;
            w_next.we       = WRITEENABLE;
            w_next.memread  = MEMREAD;
            w_next.memwrite = MEMWRITE;
            w_next.branch   = BRANCH;
            w_next.jump     = JUMP;
            w_next.rd       = INSTRUCTION[11:7];
            w_next.rs1      = INSTRUCTION[19:15];
            w_next.rs2      = INSTRUCTION[24:20];
            w_next.funct3   = INSTRUCTION[14:12];
        end
    end

    // Pipeline register: reset wins over hold, hold freezes everything.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_ex <= '0;
        end else if (HOLD) begin
            r_ex <= r_ex;
        end else begin
            r_ex <= w_next;
        end
    end

    assign EX_VALID       = r_ex.valid;
    assign EX_PC          = r_ex.pc;
    assign EX_DATA1       = r_ex.data1;
    assign EX_DATA2       = r_ex.data2;
    assign EX_IMM         = r_ex.imm;
    assign EX_ALUOP       = r_ex.aluop;
    assign EX_MUX1        = r_ex.mux1;
    assign EX_MUX2        = r_ex.mux2;
    assign EX_MUX3        = r_ex.mux3;
    assign EX_MUX4        = r_ex.mux4;
    assign EX_WRITEENABLE = r_ex.we;
    assign EX_MEMREAD     = r_ex.memread;
    assign EX_MEMWRITE    = r_ex.memwrite;
    assign EX_BRANCH      = r_ex.branch;
    assign EX_JUMP        = r_ex.jump;
    assign EX_RD          = r_ex.rd;
    assign EX_RS1         = r_ex.rs1;
    assign EX_RS2         = r_ex.rs2;
    assign EX_FUNCT3      = r_ex.funct3;
    assign LOAD_USE_STALL = w_stall;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the ID/EX register and hazard rule.
module tb_id_ex_pipeline_reg;
    import rv32_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, ID_VALID, HOLD, FLUSH;
    logic [31:0] INSTRUCTION, ID_PC, ID_DATA1, ID_DATA2, ID_IMM;
    logic [4:0]  ALUOP;
    logic        MUX1_SELECT, MUX2_SELECT, MUX3_SELECT, MUX4_SELECT;
    logic        WRITEENABLE, MEMREAD, MEMWRITE, BRANCH, JUMP;
    logic        EX_VALID, EX_MUX1, EX_MUX2, EX_MUX3, EX_MUX4;
    logic        EX_WRITEENABLE, EX_MEMREAD, EX_MEMWRITE, EX_BRANCH, EX_JUMP;
    logic [31:0] EX_PC, EX_DATA1, EX_DATA2, EX_IMM;
    logic [4:0]  EX_ALUOP, EX_RD, EX_RS1, EX_RS2;
    logic [2:0]  EX_FUNCT3;
    logic        LOAD_USE_STALL;

    always #5 CLK = ~CLK;

    id_ex_pipeline_reg dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .ID_VALID(ID_VALID),
        .ID_PC(ID_PC), .ID_DATA1(ID_DATA1), .ID_DATA2(ID_DATA2), .ID_IMM(ID_IMM),
        .ALUOP(ALUOP), .MUX1_SELECT(MUX1_SELECT), .MUX2_SELECT(MUX2_SELECT),
        .MUX3_SELECT(MUX3_SELECT), .MUX4_SELECT(MUX4_SELECT),
        .WRITEENABLE(WRITEENABLE), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
        .BRANCH(BRANCH), .JUMP(JUMP), .HOLD(HOLD), .FLUSH(FLUSH),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2),
        .EX_IMM(EX_IMM), .EX_ALUOP(EX_ALUOP), .EX_MUX1(EX_MUX1), .EX_MUX2(EX_MUX2),
        .EX_MUX3(EX_MUX3), .EX_MUX4(EX_MUX4), .EX_WRITEENABLE(EX_WRITEENABLE),
        .EX_MEMREAD(EX_MEMREAD), .EX_MEMWRITE(EX_MEMWRITE), .EX_BRANCH(EX_BRANCH),
        .EX_JUMP(EX_JUMP), .EX_RD(EX_RD), .EX_RS1(EX_RS1), .EX_RS2(EX_RS2),
        .EX_FUNCT3(EX_FUNCT3), .LOAD_USE_STALL(LOAD_USE_STALL)
    );

    // Model view of the EX stage, field order matching dut_vec below.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  aluop;
        logic        m1, m2, m3, m4, we, mr, mw, br, jp;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
    } ex_t;

    localparam logic [8:0] CTL_ALU = 9'b0000_10000;
    localparam logic [8:0] CTL_LD  = 9'b0100_11000;
    localparam logic [8:0] CTL_ALL = 9'b1111_11111;

    ex_t          m;
    logic         m_known = 1'b0;
    logic [160:0] dut_vec;
    int           n_cmp = 0;
    int           n_bad = 0;

    assign dut_vec = {EX_VALID, EX_PC, EX_DATA1, EX_DATA2, EX_IMM, EX_ALUOP,
                      EX_MUX1, EX_MUX2, EX_MUX3, EX_MUX4, EX_WRITEENABLE,
                      EX_MEMREAD, EX_MEMWRITE, EX_BRANCH, EX_JUMP,
                      EX_RD, EX_RS1, EX_RS2, EX_FUNCT3};

    // The FLUSH source is never allowed to fire while EX is busy.
    always @(posedge CLK) begin
        if (RESET === 1'b1 && HOLD === 1'b1) begin
            assert (FLUSH !== 1'b1) else $error("FAIL flush_during_hold");
        end
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'd0, rd, OP_RTYPE};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'd2, rd, OP_LOAD};
    endfunction

    // Hazard rule stated directly from the operand-usage table.
    function automatic logic model_stall();
        logic [6:0] op;
        logic       r1, r2;
        op = INSTRUCTION[6:0];
        r1 = op inside {OP_RTYPE, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH};
        r2 = op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
        return m.v && m.mr && (m.rd != 5'd0) && ID_VALID &&
               ((r1 && INSTRUCTION[19:15] == m.rd) || (r2 && INSTRUCTION[24:20] == m.rd));
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        n = '0;
        if (!RESET)                                    n = '0;
        else if (HOLD)                                 n = m;
        else if (FLUSH || model_stall() || !ID_VALID)  n = '0;
        else begin
            n.v = 1'b1; n.pc = ID_PC; n.d1 = ID_DATA1; n.d2 = ID_DATA2; n.imm = ID_IMM;
            n.aluop = ALUOP;
            {n.m1, n.m2, n.m3, n.m4} = {MUX1_SELECT, MUX2_SELECT, MUX3_SELECT, MUX4_SELECT};
            {n.we, n.mr, n.mw, n.br, n.jp} = {WRITEENABLE, MEMREAD, MEMWRITE, BRANCH, JUMP};
            n.rd = INSTRUCTION[11:7]; n.rs1 = INSTRUCTION[19:15];
            n.rs2 = INSTRUCTION[24:20]; n.f3 = INSTRUCTION[14:12];
        end
        return n;
    endfunction

    // One clock: check the stall on current inputs, advance, check EX state.
    task automatic cyc();
        ex_t n;
        #1;
        if (m_known) check("stall", {199'd0, LOAD_USE_STALL}, {199'd0, model_stall()});
        n = model_next();
        @(posedge CLK);
        m = n;
        m_known = 1'b1;
        #1;
        check("ex_all", {39'd0, dut_vec}, {39'd0, m});
    endtask

    task automatic drive(input logic [31:0] ins, input logic [4:0] op, input logic [8:0] ctl);
        INSTRUCTION = ins; ID_VALID = 1'b1; ALUOP = op;
        ID_PC = $urandom; ID_DATA1 = $urandom; ID_DATA2 = $urandom; ID_IMM = $urandom;
        {MUX1_SELECT, MUX2_SELECT, MUX3_SELECT, MUX4_SELECT} = ctl[8:5];
        {WRITEENABLE, MEMREAD, MEMWRITE, BRANCH, JUMP} = ctl[4:0];
        RESET = 1'b1; HOLD = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic rand_inputs();
        logic [6:0] ops [10];
        logic [6:0] op;
        ops = '{OP_RTYPE, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_AUIPC,
                OP_LUI, OP_BRANCH, OP_JAL, 7'b1110011};
        op = ops[$urandom_range(0, 9)];
        INSTRUCTION = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       3'($urandom), 5'($urandom_range(0, 3)), op};
        ID_VALID = ($urandom_range(0, 7) != 0);
        ID_PC = $urandom; ID_DATA1 = $urandom; ID_DATA2 = $urandom; ID_IMM = $urandom;
        ALUOP = 5'($urandom_range(0, 18));
        {MUX1_SELECT, MUX2_SELECT, MUX3_SELECT, MUX4_SELECT} = 4'($urandom);
        {WRITEENABLE, MEMREAD, MEMWRITE, BRANCH, JUMP} = 5'($urandom);
    endtask

    initial begin
        logic [31:0] nfs_ins [4];
        logic [4:0]  nfs_rd  [4];
        logic        nfs_exp [4];

        // Reset with random ID-side traffic.
        RESET = 1'b0; HOLD = 1'b0; FLUSH = 1'b0;
        rand_inputs();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            HOLD = 1'($urandom);
            cyc();
            check("rst_zero", {39'd0, dut_vec}, 200'd0);
            check("rst_stall", {199'd0, LOAD_USE_STALL}, 200'd0);
        end

        // First instruction after reset: ADD x3,x1,x2.
        drive(enc_r(7'd0, 5'd3, 5'd1, 5'd2), ALU_ADD, CTL_ALU);
        ID_DATA1 = 32'd5; ID_DATA2 = 32'd7;
        cyc();
        check("add_valid", {199'd0, EX_VALID}, 200'd1);
        check("add_aluop", {195'd0, EX_ALUOP}, 200'd1);
        check("add_rd",    {195'd0, EX_RD}, 200'd3);
        check("add_we",    {199'd0, EX_WRITEENABLE}, 200'd1);
        check("add_data1", {168'd0, EX_DATA1}, 200'd5);
        check("add_data2", {168'd0, EX_DATA2}, 200'd7);

        // Load-use: LW x5,0(x1) then ADD x6,x5,x2.
        drive(enc_lw(5'd5, 5'd1), ALU_ADD, CTL_LD);
        cyc();
        drive(enc_r(7'd0, 5'd6, 5'd5, 5'd2), ALU_ADD, CTL_ALU);
        #1;
        check("lu_stall", {199'd0, LOAD_USE_STALL}, 200'd1);
        cyc();
        check("lu_bubble_v",  {199'd0, EX_VALID}, 200'd0);
        check("lu_bubble_we", {199'd0, EX_WRITEENABLE}, 200'd0);
        #1;
        check("lu_stall_once", {199'd0, LOAD_USE_STALL}, 200'd0);
        cyc();
        check("lu_consumer_v",   {199'd0, EX_VALID}, 200'd1);
        check("lu_consumer_rs1", {195'd0, EX_RS1}, 200'd5);

        // Consumers that must or must not stall behind a load.
        nfs_ins = '{{20'h12345, 5'd5, OP_LUI},
                    {7'd0, 5'd7, 5'd5, 3'd2, 5'd0, OP_STORE},
                    enc_r(7'd0, 5'd6, 5'd0, 5'd0),
                    enc_r(7'd0, 5'd6, 5'd0, 5'd0)};
        nfs_rd  = '{5'd5, 5'd5, 5'd5, 5'd0};
        nfs_exp = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(enc_lw(nfs_rd[i], 5'd1), ALU_ADD, CTL_LD);
            cyc();
            drive(nfs_ins[i], ALU_ADD, CTL_ALU);
            #1;
            check($sformatf("nfs_stall%0d", i), {199'd0, LOAD_USE_STALL}, {199'd0, nfs_exp[i]});
            cyc();
        end

        // Flush kills a valid SUB with every control bit set.
        drive({7'b0100000, 5'd2, 5'd1, 3'd0, 5'd4, OP_RTYPE}, ALU_SUB, CTL_ALL);
        FLUSH = 1'b1;
        cyc();
        check("fl_valid", {199'd0, EX_VALID}, 200'd0);
        check("fl_ctrl",  {197'd0, EX_MEMWRITE, EX_BRANCH, EX_JUMP}, 200'd0);

        // Hold with MUL x8,x1,x2 in EX while ID changes.
        drive(enc_r(7'd1, 5'd8, 5'd1, 5'd2), ALU_MUL, CTL_ALU);
        cyc();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            HOLD = 1'b1;
            cyc();
            check("hold_aluop", {195'd0, EX_ALUOP}, {195'd0, ALU_MUL});
            check("hold_rd",    {195'd0, EX_RD}, 200'd8);
        end
        drive(enc_r(7'd0, 5'd9, 5'd3, 5'd4), ALU_ADD, CTL_ALU);
        ID_PC = 32'h0000_1234;
        cyc();
        check("release_pc", {168'd0, EX_PC}, 200'h1234);
        check("release_rd", {195'd0, EX_RD}, 200'd9);

        // Hold stretches an active load-use stall.
        drive(enc_lw(5'd5, 5'd1), ALU_ADD, CTL_LD);
        cyc();
        drive(enc_r(7'd0, 5'd6, 5'd5, 5'd2), ALU_ADD, CTL_ALU);
        HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_lu_stall", {199'd0, LOAD_USE_STALL}, 200'd1);
            cyc();
        end
        HOLD = 1'b0;
        cyc();
        check("hold_lu_bubble", {199'd0, EX_VALID}, 200'd0);

        // Reset beats hold.
        drive(enc_r(7'd1, 5'd8, 5'd1, 5'd2), ALU_MUL, CTL_ALL);
        cyc();
        HOLD = 1'b1; RESET = 1'b0;
        cyc();
        check("rst_hold_zero", {39'd0, dut_vec}, 200'd0);
        RESET = 1'b1; HOLD = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            RESET = ($urandom_range(0, 39) != 0);
            HOLD  = ($urandom_range(0, 4) == 0);
            FLUSH = HOLD ? 1'b0 : ($urandom_range(0, 9) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
